// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 2-digit multiplexed 7-segment display path.
// The segment patterns are in "lit" polarity (1 = segment on), bit0 = a
// through bit6 = g. The display driver uses the same constants, so the
// transmit and receive ends cannot disagree on what a digit looks like.
//   DIGIT_W          width of one BCD digit
//   SEG_0..SEG_9     lit patterns of the ten decimal digits
//   SEG_DASH         lit pattern of a lone middle bar
//   SEG_BLANK        all segments off
//   state_e          sampling FSM states of seg7_mux_decoder
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd
// Purely combinational decoder from a lit 7-segment pattern to one BCD digit.
// Only the ten exact digit patterns are accepted; anything else (dash, blank,
// ghosted or partial patterns) is reported as not valid.
//   seg_i    in   7  lit segment pattern, bit0 = a ... bit6 = g
//   valid_o  out  1  pattern is one of the ten decimal digits
//   digit_o  out  4  decoded digit, 0 when valid_o is low
// ---------------------------------------------------------------------------
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0]         seg_i,
  output logic               valid_o,
  output logic [DIGIT_W-1:0] digit_o
);

  // Exact-match lookup; the dash and blank patterns are listed so the
  // intentionally rejected display states are visible next to the digits.
  always_comb begin
    valid_o = 1'b1;
    digit_o = '0;
    case (seg_i)
      SEG_0: digit_o = 4'd0;
      SEG_1: digit_o = 4'd1;
      SEG_2: digit_o = 4'd2;
      SEG_3: digit_o = 4'd3;
      SEG_4: digit_o = 4'd4;
      SEG_5: digit_o = 4'd5;
      SEG_6: digit_o = 4'd6;
      SEG_7: digit_o = 4'd7;
      SEG_8: digit_o = 4'd8;
      SEG_9: digit_o = 4'd9;
      SEG_DASH, SEG_BLANK: valid_o = 1'b0;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_decoder.sv
// ---------------------------------------------------------------------------
// seg7_mux_decoder
// Watches the pins of a 2-digit multiplexed 7-segment display and rebuilds
// the value being shown. Each digit-select edge starts a settle window; at
// its end the (synchronised) segments are decoded into the tens or ones
// slot. A ones digit following a tens digit completes a frame.
//   i_clk    in   1  system clock
//   i_rst    in   1  synchronous active-high reset
//   i_seg    in   7  raw segment pins, active-low, bit0 = a ... bit6 = g
//   i_sel    in   1  raw digit select, 0 = tens shown, 1 = ones shown
//   o_tens   out  4  last good tens digit
//   o_ones   out  4  last good ones digit
//   o_value  out  7  o_tens * 10 + o_ones
//   o_valid  out  1  pulse: a new good frame was loaded
//   o_err    out  1  pulse: a frame completed with an undecodable digit
//   o_stale  out  1  level: select has not toggled for TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module seg7_mux_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int CNT_W          = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [6:0]         i_seg,
  input  logic               i_sel,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones,
  output logic [6:0]         o_value,
  output logic               o_valid,
  output logic               o_err,
  output logic               o_stale
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [6:0]         segMeta_q, segSync_q;
  logic               selMeta_q, selSync_q, selPrev_q;
  logic [6:0]         segLit;
  logic               selEdge;
  logic               timeoutHit;
  logic               decValid;
  logic [DIGIT_W-1:0] decDigit;
  logic [6:0]         value_d;

  state_e             state_q;
  logic [CNT_W-1:0]   settleCnt_q;
  logic [CNT_W-1:0]   toCnt_q;
  logic               haveTens_q;
  logic [DIGIT_W-1:0] tensSlot_q;
  logic               tensOk_q;
  logic [DIGIT_W-1:0] tens_q, ones_q;
  logic [6:0]         value_q;
  logic               valid_q, err_q, stale_q;

  // Two-flop synchronisers for the asynchronous display pins. Reset values
  // mean "tens selected, all segments dark", and the extra select copy is
  // reset to the same level so no edge is seen right after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      segMeta_q <= 7'h7F;
      segSync_q <= 7'h7F;
      selMeta_q <= 1'b0;
      selSync_q <= 1'b0;
      selPrev_q <= 1'b0;
    end else begin
      segMeta_q <= i_seg;
      segSync_q <= segMeta_q;
      selMeta_q <= i_sel;
      selSync_q <= selMeta_q;
      selPrev_q <= selSync_q;
    end
  end

  assign segLit     = ~segSync_q;
  assign selEdge    = selSync_q ^ selPrev_q;
  assign timeoutHit = !selEdge && (toCnt_q == TIMEOUT_LAST);

  seg7_to_bcd uDecode (
    .seg_i   (segLit),
    .valid_o (decValid),
    .digit_o (decDigit)
  );

  // tens * 10 + ones as shift-and-add, kept 7 bits wide (maximum 99).
  assign value_d = (7'(tensSlot_q) << 3) + (7'(tensSlot_q) << 1) + 7'(decDigit);

  // Sampling FSM, frame assembly and timeout in one block so every output
  // is a register. In SAMPLE, selPrev_q still holds the select level of the
  // phase being captured, even if a new edge arrives in that same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      settleCnt_q <= '0;
      toCnt_q     <= '0;
      haveTens_q  <= 1'b0;
      tensSlot_q  <= '0;
      tensOk_q    <= 1'b0;
      tens_q      <= '0;
      ones_q      <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (selEdge) begin
        toCnt_q <= '0;
      end else if (toCnt_q != TIMEOUT_SAT) begin
        toCnt_q <= toCnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (selEdge) begin
            state_q     <= ST_SETTLE;
            settleCnt_q <= '0;
          end
        end
        ST_SETTLE: begin
          // A new edge means the phase being settled was cut short.
          if (selEdge) begin
            settleCnt_q <= '0;
          end else if (settleCnt_q == SETTLE_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            settleCnt_q <= settleCnt_q + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (!selPrev_q) begin
            tensSlot_q <= decDigit;
            tensOk_q   <= decValid;
            haveTens_q <= 1'b1;
          end else begin
            haveTens_q <= 1'b0;
            // A ones digit without a preceding tens digit is a partial
            // frame from starting mid-scan and is dropped silently.
            if (haveTens_q) begin
              if (tensOk_q && decValid) begin
                tens_q  <= tensSlot_q;
                ones_q  <= decDigit;
                value_q <= value_d;
                valid_q <= 1'b1;
                stale_q <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          settleCnt_q <= '0;
          state_q     <= selEdge ? ST_SETTLE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (timeoutHit) begin
        stale_q    <= 1'b1;
        haveTens_q <= 1'b0;
        state_q    <= ST_IDLE;
      end
    end
  end

  assign o_tens  = tens_q;
  assign o_ones  = ones_q;
  assign o_value = value_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_stale = stale_q;

endmodule

// File: doc/seg7_mux_decoder.md
Name: seg7_mux_decoder

Overview:
- Receive-side counterpart of the dual 7-segment display driver: it samples the active-low segment lines and the digit-select line of a 2-digit multiplexed display and reconstructs the displayed value (0..99).
- Used for board-level loopback and self-check of the timer/counter display path, and as a bench monitor.
- Purely sampled: it never drives the display.

Parameters:
- SETTLE_CYCLES, 16, clock cycles to wait after a select edge before sampling segments (absorbs skew/ghosting); minimum 1.
- TIMEOUT_CYCLES, 600000, max cycles between select edges before the link is declared stale (27 MHz / 45 Hz).
- CNT_W, 20, width of the shared settle/timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock (27 MHz).
- i_rst  in  1  reset, synchronous and active-high.
- i_seg  in  7  raw segment pins, active-low; bit0=a … bit6=g.
- i_sel  in  1  raw digit select: 0 = tens digit shown, 1 = ones digit shown.
- o_tens  out  4  last good tens digit (BCD).
- o_ones  out  4  last good ones digit (BCD).
- o_value  out  7  o_tens*10 + o_ones, binary.
- o_valid  out  1  one-cycle pulse: new good frame loaded into o_tens/o_ones/o_value.
- o_err  out  1  one-cycle pulse: frame completed but a digit pattern was not decodable.
- o_stale  out  1  level: no select edge for TIMEOUT_CYCLES; cleared on the next good frame.

Behaviour:
- Input conditioning:
  - i_seg and i_sel each pass through 2-flop synchronizers.
  - Segments are inverted after sync, so 1 = lit.
  - A select edge is sync-stage-2 differing from its registered copy.
- Decode (combinational on inverted segments):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9.
  - Every other pattern, including 0x40 (dash) and 0x00 (blank), is invalid.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE: wait for any select edge → SETTLE, counter cleared.
  - SETTLE: count to SETTLE_CYCLES-1, then → SAMPLE. Another select edge during SETTLE restarts the count; the partial phase is discarded.
  - SAMPLE (1 cycle): capture the decoded digit and its valid bit into the tens slot (sel=0) or ones slot (sel=1), then → IDLE.
- Frame assembly:
  - have_tens is set by a tens capture and cleared by a ones capture.
  - A ones capture with have_tens=1 completes a frame.
  - A ones capture with have_tens=0 (decoder started mid-frame) produces no output.
  - A second tens capture overwrites the tens slot.
- Frame result, registered the cycle after the ones SAMPLE:
  - Both digits valid: update o_tens, o_ones, o_value; pulse o_valid; clear o_stale.
  - Either digit invalid: pulse o_err; hold the previous outputs.
  - o_valid and o_err are never high together.
- Latency: from the i_sel pin edge, capture is at cycle 2+1+SETTLE_CYCLES and o_valid/o_err at cycle 4+SETTLE_CYCLES (20 with defaults).
- Arithmetic: o_value = tens*8 + tens*2 + ones, computed 7 bits wide; maximum 99, so no overflow.
- Timeout:
  - An independent counter clears on every select edge and saturates.
  - On reaching TIMEOUT_CYCLES: o_stale=1, have_tens cleared, FSM → IDLE.
  - Data outputs hold their last values.
- Reset (any cycle, including mid-SETTLE):
  - FSM → IDLE; counters and have_tens cleared.
  - o_tens=0, o_ones=0, o_value=0, o_valid=0, o_err=0, o_stale=0.
  - Synchronizers are reset to sel=0 and segments-off (i_seg=0x7F raw).
  - No select edge is detected in the first cycle after reset.

Decomposition:
- Package seg7_pkg: segment-pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), FSM state enum, DIGIT_W=4.
  - The display driver shares the same pattern constants so both ends stay consistent.
- One sub-module, seg7_to_bcd: pattern → {valid, digit[3:0]}, purely combinational, testable in isolation.
- Synchronizers, FSM and frame logic stay in the top module.

Test Plan:
- Decode 42: drive sel=0 with seg=~0x66, 300000 cycles later sel=1 with seg=~0x5B, then sel=0 → one o_valid pulse; o_tens=4, o_ones=2, o_value=42, exactly 20 cycles after the sel rising edge.
- Invalid digit: tens=5, ones pattern ~0x40 (dash) → o_err pulses once, o_valid stays 0, outputs hold 42.
- Settle glitch: after a sel edge, change seg from ~0x3F to ~0x06 at settle cycle 8 → captured digit is 1. A second sel toggle at cycle 10 restarts settle and is not captured early.
- Mid-frame start: release reset while sel=1 showing 7, then run a full 3/7 frame → no output on the first ones phase; the first o_valid carries o_value=37.
- Timeout: hold sel constant 600000 cycles → o_stale=1, outputs unchanged. The next good frame 59 → o_valid, o_value=59, o_stale=0.
- Reset mid-SETTLE: assert i_rst for 1 cycle at settle count 5 → all outputs 0, no o_valid or o_err from the interrupted phase, and the next full frame 00 gives o_valid with o_value=0.
